// File: rtl/pos_pkg.sv
// Shared constants, FSM state type and BCD helper for the POS menu totaliser.
package pos_pkg;

    localparam int unsigned NUM_ITEMS   = 4;
    localparam int unsigned CONV_CYCLES = 20;
    localparam int unsigned ACC_W       = 20;
    localparam int unsigned BCD_W       = 24;
    localparam int unsigned NUM_DIGITS  = 6;
    localparam int unsigned PRICE_W     = 16;
    localparam int unsigned CNT_W       = 3;
    localparam int unsigned SEL_W       = 4;
    localparam int unsigned IDX_W       = 2;
    localparam int unsigned RES_W       = 24;
    localparam int unsigned STR_W       = 128;

    localparam logic [7:0] SPACE = 8'h20;
    localparam logic [7:0] ZERO  = 8'h30;
    localparam logic [7:0] EQ    = 8'h3D;
    localparam logic [7:0] LPAR  = 8'h28;
    localparam logic [7:0] RPAR  = 8'h29;
    localparam logic [7:0] LET_S = 8'h53;
    localparam logic [7:0] LET_U = 8'h55;
    localparam logic [7:0] LET_M = 8'h4D;

    localparam logic [PRICE_W-1:0] PRICE0_DEF = 16'd10000;
    localparam logic [PRICE_W-1:0] PRICE1_DEF = 16'd7000;
    localparam logic [PRICE_W-1:0] PRICE2_DEF = 16'd7000;
    localparam logic [PRICE_W-1:0] PRICE3_DEF = 16'd4000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        CONV = 2'd2,
        LOAD = 2'd3
    } state_t;

    // One double-dabble iteration: add 3 to every digit >= 5, then shift in one binary bit.
    function automatic logic [BCD_W-1:0] dabble_step(input logic [BCD_W-1:0] bcd,
                                                     input logic din);
        logic [BCD_W-1:0] adj;
        adj = bcd;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (adj[4*i +: 4] >= 4'd5) begin
                adj[4*i +: 4] = adj[4*i +: 4] + 4'd3;
            end
        end
        return {adj[BCD_W-2:0], din};
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter: one shift-add-3 step per clock, 20 steps per conversion.
// start loads the operand and performs the first step; done_c is high in the cycle of the last step.
module bin2bcd_seq
    import pos_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [ACC_W-1:0] bin,
    output logic [BCD_W-1:0] bcd,
    output logic             done_c
);

    localparam int unsigned REM_W = 5;

    logic [ACC_W-1:0] sh;
    logic [REM_W-1:0] rem;

    // Shift register, digit accumulator and remaining-step counter
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcd <= '0;
            sh  <= '0;
            rem <= '0;
        end else if (start) begin
            bcd <= dabble_step('0, bin[ACC_W-1]);
            sh  <= {bin[ACC_W-2:0], 1'b0};
            rem <= REM_W'(CONV_CYCLES - 1);
        end else if (rem != '0) begin
            bcd <= dabble_step(bcd, sh[ACC_W-1]);
            sh  <= {sh[ACC_W-2:0], 1'b0};
            rem <= rem - REM_W'(1);
        end
    end

    // Final step is the one taken while a single step remains
    always_comb begin
        done_c = (rem == REM_W'(1));
    end

endmodule

// File: rtl/menu_sum_seq.sv
// Menu-price totaliser: synchronises the DIP selection, sums prices one item per clock,
// converts the total to decimal and publishes a 16-character LCD string.
// Optional MENU_SUM_ZERO_BLANK_EN: blank leading zeros in the five upper digit columns.
module menu_sum_seq
    import pos_pkg::*;
#(
    parameter logic [PRICE_W-1:0] PRICE0 = PRICE0_DEF,
    parameter logic [PRICE_W-1:0] PRICE1 = PRICE1_DEF,
    parameter logic [PRICE_W-1:0] PRICE2 = PRICE2_DEF,
    parameter logic [PRICE_W-1:0] PRICE3 = PRICE3_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [SEL_W-1:0] menu_sel,
    input  logic             recalc,
    output logic [STR_W-1:0] disp_str_flat,
    output logic [RES_W-1:0] result,
    output logic             result_valid,
    output logic             busy,
    output logic [CNT_W-1:0] num_sel
);

    state_t             state;
    state_t             state_nxt;
    logic [SEL_W-1:0]   sync1;
    logic [SEL_W-1:0]   sel_sync;
    logic [SEL_W-1:0]   sel_cur;
    logic               pending;
    logic               conv_run;
    logic [IDX_W-1:0]   idx;
    logic [ACC_W-1:0]   acc;
    logic [CNT_W-1:0]   cnt;
    logic [BCD_W-1:0]   bcd;
    logic               done_c;
    logic               req_c;
    logic               trig_c;
    logic               scan_c;
    logic               start_c;
    logic               load_c;
    logic [PRICE_W-1:0] price_c;
    logic [STR_W-1:0]   str_c;

    bin2bcd_seq u_bcd (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start_c),
        .bin    (acc),
        .bcd    (bcd),
        .done_c (done_c)
    );

    // A new pass is wanted when the selection moved, a pass is owed, or recalc pulses
    always_comb begin
        req_c = (sel_sync != sel_cur) || pending || recalc;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (req_c) state_nxt = SCAN;
            SCAN:    if (idx == IDX_W'(NUM_ITEMS - 1)) state_nxt = CONV;
            CONV:    if (done_c) state_nxt = LOAD;
            LOAD:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Datapath strobes decoded from the current state
    always_comb begin
        trig_c  = 1'b0;
        scan_c  = 1'b0;
        start_c = 1'b0;
        load_c  = 1'b0;
        case (state)
            IDLE:    trig_c  = req_c;
            SCAN:    scan_c  = 1'b1;
            CONV:    start_c = !conv_run;
            LOAD:    load_c  = 1'b1;
            default: ;
        endcase
    end

    // Price of the item currently being scanned
    always_comb begin
        case (idx)
            2'd0:    price_c = PRICE0;
            2'd1:    price_c = PRICE1;
            2'd2:    price_c = PRICE2;
            default: price_c = PRICE3;
        endcase
    end

    // Display string: "SUM=dddddd  (n) ", column 0 in the low byte
    always_comb begin
        logic [3:0] dig;
        logic [7:0] ch;
`ifdef MENU_SUM_ZERO_BLANK_EN
        logic       lead;
        lead = 1'b1;
`endif
        str_c = {16{SPACE}};
        str_c[8*0 +: 8]  = LET_S;
        str_c[8*1 +: 8]  = LET_U;
        str_c[8*2 +: 8]  = LET_M;
        str_c[8*3 +: 8]  = EQ;
        for (int j = 0; j < int'(NUM_DIGITS); j++) begin
            dig = bcd[4*(int'(NUM_DIGITS) - 1 - j) +: 4];
            ch  = ZERO + {4'h0, dig};
`ifdef MENU_SUM_ZERO_BLANK_EN
            if (lead && (dig == 4'd0) && (j < int'(NUM_DIGITS) - 1)) ch = SPACE;
            else lead = 1'b0;
`endif
            str_c[8*(4+j) +: 8] = ch;
        end
        str_c[8*12 +: 8] = LPAR;
        str_c[8*13 +: 8] = ZERO + {5'h0, cnt};
        str_c[8*14 +: 8] = RPAR;
    end

    // Synchroniser, accumulator, pass bookkeeping and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1         <= '0;
            sel_sync      <= '0;
            sel_cur       <= '0;
            pending       <= 1'b1;
            conv_run      <= 1'b0;
            idx           <= '0;
            acc           <= '0;
            cnt           <= '0;
            disp_str_flat <= {16{SPACE}};
            result        <= '0;
            result_valid  <= 1'b0;
            busy          <= 1'b0;
            num_sel       <= '0;
        end else begin
            sync1    <= menu_sel;
            sel_sync <= sync1;
            busy     <= (state_nxt != IDLE);
            if (recalc && (state != IDLE)) pending <= 1'b1;
            if (trig_c) begin
                sel_cur      <= sel_sync;
                pending      <= 1'b0;
                acc          <= '0;
                cnt          <= '0;
                idx          <= '0;
                result_valid <= 1'b0;
            end
            if (scan_c) begin
                if (sel_cur[idx]) begin
                    acc <= acc + ACC_W'(price_c);
                    cnt <= cnt + CNT_W'(1);
                end
                idx <= idx + IDX_W'(1);
            end
            if (start_c) conv_run <= 1'b1;
            if (load_c) begin
                conv_run      <= 1'b0;
                disp_str_flat <= str_c;
                result        <= {4'b0, acc};
                num_sel       <= cnt;
                result_valid  <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_menu_sum_seq.sv
// Directed bench for menu_sum_seq: vector table plus hand-written multi-cycle sequences.
module tb_menu_sum_seq;

    logic         clk;
    logic         rst_n;
    logic [3:0]   menu_sel;
    logic         recalc;
    logic [127:0] disp_str_flat;
    logic [23:0]  result;
    logic         result_valid;
    logic         busy;
    logic [2:0]   num_sel;

    int total;
    int passed;

    typedef struct {
        logic [3:0]  sel;
        logic [23:0] res;
        logic [2:0]  n;
        string       plain;
        string       blank;
    } vec_t;

    vec_t vecs[8];

    menu_sum_seq dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .menu_sel      (menu_sel),
        .recalc        (recalc),
        .disp_str_flat (disp_str_flat),
        .result        (result),
        .result_valid  (result_valid),
        .busy          (busy),
        .num_sel       (num_sel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] mk(input string s);
        logic [127:0] v;
        v = '0;
        for (int k = 0; k < 16; k++) v[8*k +: 8] = s[k];
        return v;
    endfunction

    function automatic logic [127:0] pick(input string plain, input string blank);
`ifdef MENU_SUM_ZERO_BLANK_EN
        return mk(blank);
`else
        if (blank.len() == 0) return mk(plain);
        return mk(plain);
`endif
    endfunction

    function automatic string to_str(input logic [127:0] v);
        string s;
        s = "";
        for (int k = 0; k < 16; k++) s = $sformatf("%s%c", s, v[8*k +: 8]);
        return s;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", name, act, exp);
        else passed++;
    endtask

    task automatic chk_s(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got \"%s\" expected \"%s\"", name, to_str(act), to_str(exp));
        else passed++;
    endtask

    task automatic set_vec(input int i, input logic [3:0] sel, input logic [23:0] res,
                           input logic [2:0] n, input string plain, input string blank);
        vecs[i].sel   = sel;
        vecs[i].res   = res;
        vecs[i].n     = n;
        vecs[i].plain = plain;
        vecs[i].blank = blank;
    endtask

    // Apply a selection, follow one pass to completion and check timing, hold and results.
    // act_kind 1 changes menu_sel, 2 pulses recalc, at act_at clocks after the trigger.
    task automatic do_pass(input string tag, input logic [3:0] sel, input logic [23:0] res,
                           input logic [2:0] n, input logic [127:0] str,
                           input int act_kind, input int act_at, input logic [3:0] act_sel);
        bit           ok;
        bit           hold;
        int           lat;
        int           bcnt;
        logic [127:0] s0;
        logic [23:0]  r0;
        menu_sel = sel;
        ok = 1'b0;
        for (int i = 0; i < 20 && !ok; i++) begin
            if (busy) ok = 1'b1;
            else @(negedge clk);
        end
        chk({tag, "_start"}, 32'(ok), 32'd1);
        if (!ok) return;
        s0   = disp_str_flat;
        r0   = result;
        lat  = 0;
        bcnt = 1;
        hold = 1'b1;
        while (!result_valid && lat < 60) begin
            @(negedge clk);
            lat++;
            if (recalc) recalc = 1'b0;
            if (lat == act_at) begin
                if (act_kind == 1) menu_sel = act_sel;
                else if (act_kind == 2) recalc = 1'b1;
            end
            if (busy) bcnt++;
            if (!result_valid && (disp_str_flat !== s0 || result !== r0)) hold = 1'b0;
        end
        recalc = 1'b0;
        chk({tag, "_latency"}, 32'(lat), 32'd25);
        chk({tag, "_busy_cycles"}, 32'(bcnt), 32'd25);
        chk({tag, "_hold"}, 32'(hold), 32'd1);
        chk({tag, "_result"}, 32'(result), 32'(res));
        chk({tag, "_num_sel"}, 32'(num_sel), 32'(n));
        chk_s({tag, "_str"}, disp_str_flat, str);
    endtask

    initial begin
        bit settled;
        int quiet;
        total    = 0;
        passed   = 0;
        rst_n    = 1'b0;
        menu_sel = 4'b0000;
        recalc   = 1'b0;

        set_vec(0, 4'b0000, 24'd0,     3'd0, "SUM=000000  (0) ", "SUM=     0  (0) ");
        set_vec(1, 4'b0001, 24'd10000, 3'd1, "SUM=010000  (1) ", "SUM= 10000  (1) ");
        set_vec(2, 4'b1111, 24'd28000, 3'd4, "SUM=028000  (4) ", "SUM= 28000  (4) ");
        set_vec(3, 4'b0110, 24'd14000, 3'd2, "SUM=014000  (2) ", "SUM= 14000  (2) ");
        set_vec(4, 4'b1000, 24'd4000,  3'd1, "SUM=004000  (1) ", "SUM=  4000  (1) ");
        set_vec(5, 4'b0011, 24'd17000, 3'd2, "SUM=017000  (2) ", "SUM= 17000  (2) ");
        set_vec(6, 4'b1101, 24'd21000, 3'd3, "SUM=021000  (3) ", "SUM= 21000  (3) ");
        set_vec(7, 4'b0000, 24'd0,     3'd0, "SUM=000000  (0) ", "SUM=     0  (0) ");

        // Reset state
        repeat (3) @(negedge clk);
        chk_s("rst_str", disp_str_flat, mk("                "));
        chk("rst_result", 32'(result), 32'd0);
        chk("rst_valid", 32'(result_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_num_sel", 32'(num_sel), 32'd0);
        rst_n = 1'b1;

        // Pass forced by reset with nothing selected
        do_pass("v0", vecs[0].sel, vecs[0].res, vecs[0].n, pick(vecs[0].plain, vecs[0].blank), 0, -1, 4'b0);

        // Table of selections
        for (int i = 1; i < 8; i++) begin
            do_pass($sformatf("v%0d", i), vecs[i].sel, vecs[i].res, vecs[i].n,
                    pick(vecs[i].plain, vecs[i].blank), 0, -1, 4'b0);
        end

        // Selection change in the 3rd CONV cycle: first pass finishes, a second follows
        do_pass("chg1", 4'b0001, 24'd10000, 3'd1, pick("SUM=010000  (1) ", "SUM= 10000  (1) "),
                1, 6, 4'b1000);
        do_pass("chg2", 4'b1000, 24'd4000, 3'd1, pick("SUM=004000  (1) ", "SUM=  4000  (1) "),
                0, -1, 4'b0);

        // Recalc from idle starts a pass; recalc while busy owes another pass
        @(negedge clk);
        recalc = 1'b1;
        do_pass("rc1", 4'b1000, 24'd4000, 3'd1, pick("SUM=004000  (1) ", "SUM=  4000  (1) "),
                2, 10, 4'b0);
        do_pass("rc2", 4'b1000, 24'd4000, 3'd1, pick("SUM=004000  (1) ", "SUM=  4000  (1) "),
                0, -1, 4'b0);
        quiet = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) quiet++;
        end
        chk("rc_no_extra_pass", 32'(quiet), 32'd0);

        // Reset asserted during SCAN
        menu_sel = 4'b0111;
        settled = 1'b0;
        for (int i = 0; i < 20 && !settled; i++) begin
            @(negedge clk);
            if (busy) settled = 1'b1;
        end
        chk("rstmid_start", 32'(settled), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_s("rstmid_str", disp_str_flat, mk("                "));
        chk("rstmid_result", 32'(result), 32'd0);
        chk("rstmid_valid", 32'(result_valid), 32'd0);
        chk("rstmid_busy", 32'(busy), 32'd0);
        chk("rstmid_num_sel", 32'(num_sel), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        settled = 1'b0;
        quiet = 0;
        for (int i = 0; i < 200 && !settled; i++) begin
            @(negedge clk);
            if (result_valid && !busy) quiet++;
            else quiet = 0;
            if (quiet >= 5) settled = 1'b1;
        end
        chk("rstmid_settled", 32'(settled), 32'd1);
        chk("rstmid_final_result", 32'(result), 32'd24000);
        chk("rstmid_final_num_sel", 32'(num_sel), 32'd3);
        chk_s("rstmid_final_str", disp_str_flat, pick("SUM=024000  (3) ", "SUM= 24000  (3) "));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/menu_sum_seq.md
Name: menu_sum_seq

Overview:
- Sequential menu-price totaliser for the POS display path.
- Samples the active-high DIP menu selection, accumulates the selected prices one item per clock, and converts the total to ASCII with a multi-cycle binary-to-BCD engine.
- Publishes a 16-character display string and a 24-bit result to the LCD UI renderer, with a valid flag.
- Replaces the wide combinational divide/modulo encoding in the top level with a bounded-latency sequencer.

Parameters:
- PRICE0, 16'd10000, price of menu item 0
- PRICE1, 16'd7000, price of menu item 1
- PRICE2, 16'd7000, price of menu item 2
- PRICE3, 16'd4000, price of menu item 3

Ports:
- clk  in  1  system clock (LCD pixel clock domain)
- rst_n  in  1  asynchronous active-low reset
- menu_sel  in  4  selection, bit i = item i chosen; asynchronous DIP source, already polarity-corrected
- recalc  in  1  single-cycle pulse forcing a new pass
- disp_str_flat  out  128  16 ASCII chars; char k at bits [8k+7:8k], k=0 leftmost column
- result  out  24  binary total of selected prices
- result_valid  out  1  high when the outputs reflect the latched selection
- busy  out  1  high in SCAN/CONV/LOAD
- num_sel  out  3  count of selected items, 0..4

Behaviour:
- Reset values:
  - disp_str_flat = 16 x 8'h20
  - result = 0, result_valid = 0, busy = 0, num_sel = 0
  - internal pending flag = 1, so one pass always runs after reset.
- menu_sel passes through a 2-flop synchroniser to give sel_sync.
- FSM states:
  - IDLE: if (sel_sync != sel_cur) or pending or recalc: latch sel_cur <= sel_sync, clear pending, clear accumulator, clear result_valid, go to SCAN.
  - SCAN: 4 cycles, idx 0..3. If sel_cur[idx], acc += PRICEidx and cnt += 1.
  - CONV: 20 cycles of shift-add-3 double-dabble of acc[19:0] into 6 BCD digits.
  - LOAD: 1 cycle. Register disp_str_flat, result = {4'b0, acc}, num_sel = cnt, result_valid = 1. Return to IDLE.
- Latency: outputs change and result_valid rises exactly 25 clocks after the IDLE-cycle trigger.
- disp_str_flat and result hold their previous values for the whole pass, so the display does not flicker. Only result_valid drops.
- Arithmetic widths:
  - acc is 20 bits; maximum 4 x 65535 = 262140 never overflows.
  - All 6 decimal digits are emitted.
- String format, by column:
  - 0..3: "SUM="
  - 4..9: digits, most significant first
  - 10..11: "  "
  - 12: "("
  - 13: '0'+num_sel
  - 14: ")"
  - 15: " "
- Selection change or recalc while busy: not aborted. Because sel_cur is compared again in IDLE after LOAD, the final outputs always match the last stable selection. A recalc pulse while busy sets pending.
- Zero items selected: a full pass still runs. Output is "SUM=000000  (0) ", result 0, result_valid 1.
- Reset mid-pass: immediate return to the reset values, and the pending pass reruns.

Optional Feature:
- Macro: MENU_SUM_ZERO_BLANK_EN
- Defined: leading zero digits in columns 4..8 are replaced by 8'h20. Column 9 is always a digit. The replacement is computed in LOAD, so latency is unchanged.
- Undefined: all 6 digits are printed with leading zeros.

Decomposition:
- Package pos_pkg holds:
  - ASCII constants (SPACE, ZERO, EQ, LPAR, RPAR)
  - state enum IDLE/SCAN/CONV/LOAD
  - default price constants
  - constants CONV_CYCLES = 20 and NUM_ITEMS = 4
- Sub-module bin2bcd_seq: start/done handshake, 20-bit input, 24-bit BCD output, exactly 20 cycles.
- The FSM, accumulator and string formatter stay in menu_sum_seq.

Test Plan:
- Reset released with menu_sel = 4'b0000 -> result_valid rises 25 clocks after the first IDLE trigger (plus sync); string "SUM=000000  (0) "; result 0.
- menu_sel = 4'b0001 -> result 10000, num_sel 1, string "SUM=010000  (1) "; busy high for exactly 25 cycles.
- menu_sel = 4'b1111 -> result 28000, string "SUM=028000  (4) "; then 4'b0110 -> result 14000, string "SUM=014000  (2) ".
- Change 4'b0001 to 4'b1000 on the 3rd CONV cycle -> first pass completes with 10000 (string held stable throughout), a second pass follows immediately, final result 4000.
- Assert rst_n low during SCAN -> outputs return to reset values at once; after release the pass reruns and result_valid returns with the correct total.
- MENU_SUM_ZERO_BLANK_EN defined, menu_sel = 4'b1000 -> string "SUM=  4000  (1) "; with 4'b0000 -> "SUM=     0  (0) ".
